// File: rtl/pipeline_mem_stage.sv
// Memory-access stage of the 5-stage RISC-V pipeline: EX/MEM register, req/ack data port,
// store lane/mask generation, load extraction, MEM/WB register and forwarding taps.
module pipeline_mem_stage #(
   parameter bit          MISALIGN_TRAP = 1'b1,
   parameter int unsigned MAX_WAIT      = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ex_valid_i,
   input  logic [31:0] ALU_out_EX,
   input  logic [31:0] Rs2_out_EX,
   input  logic        Half_out_EX,
   input  logic        Byte_out_EX,
   input  logic        Sign_out_EX,
   input  logic        mem_read_i,
   input  logic        mem_write_i,
   input  logic        reg_write_i,
   input  logic [4:0]  rd_i,
   input  logic [1:0]  mem_to_reg_i,
   input  logic [31:0] PC4_out_EX,
   output logic        stall_o,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wmask,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic [31:0] fwd_exmem_data,
   output logic [31:0] fwd_memwb_data,
   output logic [4:0]  exmem_rd,
   output logic        exmem_reg_write,
   output logic        wb_valid,
   output logic        wb_reg_write,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        misalign_o,
   output logic        bus_err_o
);

   typedef enum logic {ST_IDLE, ST_WAIT} state_t;

   localparam bit         TIMEOUT_EN = (MAX_WAIT != 0);
   localparam logic [7:0] WAIT_LIMIT = TIMEOUT_EN ? 8'(MAX_WAIT - 1) : 8'd0;

   state_t      state_q, state_d;
   logic [7:0]  wait_cnt;
   logic        timeout, advance, fault;

   // EX/MEM register
   logic        m_valid, m_byte, m_half, m_sign, m_read, m_write, m_reg_write, m_misalign;
   logic [31:0] m_alu, m_rs2, m_pc4;
   logic [4:0]  m_rd;
   logic [1:0]  m_mem_to_reg, m_off;

   logic        ex_mem_op, ex_is_half, ex_is_word, ex_misaligned, ex_trap;
   logic [1:0]  ex_off;
   logic [31:0] shifted, load_data, wb_sel;

   assign ex_mem_op     = ex_valid_i & (mem_read_i | mem_write_i);
   assign ex_is_half    = ~Byte_out_EX & Half_out_EX;
   assign ex_is_word    = ~Byte_out_EX & ~Half_out_EX;
   assign ex_misaligned = (ex_is_half & ALU_out_EX[0]) | (ex_is_word & (|ALU_out_EX[1:0]));
   assign ex_trap       = MISALIGN_TRAP & ex_mem_op & ex_misaligned;

   // Offset is forced to natural alignment; trapped accesses never reach the bus anyway.
   assign ex_off = ex_is_word ? 2'b00 : (ex_is_half ? {ALU_out_EX[1], 1'b0} : ALU_out_EX[1:0]);

   assign timeout = TIMEOUT_EN & (state_q == ST_WAIT) & (wait_cnt == WAIT_LIMIT) & ~mem_ack;
   assign stall_o = (state_q == ST_WAIT) & ~mem_ack & ~timeout;
   assign advance = ~stall_o;
   assign fault   = m_misalign | timeout;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      state_d = state_q;
      if (advance)
         state_d = (ex_mem_op & ~ex_trap) ? ST_WAIT : ST_IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         wait_cnt <= 8'd0;
      end else begin
         state_q  <= state_d;
         wait_cnt <= (state_q == ST_WAIT && !advance) ? wait_cnt + 8'd1 : 8'd0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid      <= 1'b0;
         m_alu        <= '0;
         m_rs2        <= '0;
         m_pc4        <= '0;
         m_byte       <= 1'b0;
         m_half       <= 1'b0;
         m_sign       <= 1'b0;
         m_read       <= 1'b0;
         m_write      <= 1'b0;
         m_reg_write  <= 1'b0;
         m_rd         <= '0;
         m_mem_to_reg <= '0;
         m_off        <= '0;
         m_misalign   <= 1'b0;
      end else if (advance) begin
         m_valid      <= ex_valid_i;
         m_alu        <= ALU_out_EX;
         m_rs2        <= Rs2_out_EX;
         m_pc4        <= PC4_out_EX;
         m_byte       <= Byte_out_EX;
         m_half       <= ex_is_half;
         m_sign       <= Sign_out_EX;
         m_read       <= mem_read_i;
         m_write      <= mem_write_i;
         m_reg_write  <= reg_write_i;
         m_rd         <= rd_i;
         m_mem_to_reg <= mem_to_reg_i;
         m_off        <= ex_off;
         m_misalign   <= ex_trap;
      end
   end

   // Bus side: everything is driven from EX/MEM so it stays stable for the whole WAIT.
   assign mem_req  = (state_q == ST_WAIT);
   assign mem_we   = mem_req & m_write;
   assign mem_addr = {m_alu[31:2], 2'b00};

   always_comb begin
      mem_wdata = '0;
      mem_wmask = 4'b0000;
      if (m_write) begin
         if (m_byte) begin
            mem_wdata = {4{m_rs2[7:0]}};
            mem_wmask = 4'b0001 << m_off;
         end else if (m_half) begin
            mem_wdata = {2{m_rs2[15:0]}};
            mem_wmask = m_off[1] ? 4'b1100 : 4'b0011;
         end else begin
            mem_wdata = m_rs2;
            mem_wmask = 4'b1111;
         end
      end
   end

   assign shifted = mem_rdata >> {m_off, 3'b000};

   always_comb begin
      load_data = shifted;
      if (m_byte)
         load_data = {{24{m_sign & shifted[7]}}, shifted[7:0]};
      else if (m_half)
         load_data = {{16{m_sign & shifted[15]}}, shifted[15:0]};
   end

   always_comb begin
      case (m_mem_to_reg)
         2'b01:   wb_sel = load_data;
         2'b10:   wb_sel = m_pc4;
         default: wb_sel = m_alu;
      endcase
   end

   // MEM/WB register; a stall retires a bubble while wb_data keeps its last value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_valid     <= 1'b0;
         wb_reg_write <= 1'b0;
         wb_rd        <= '0;
         wb_data      <= '0;
         bus_err_o    <= 1'b0;
      end else begin
         bus_err_o <= timeout;
         if (advance) begin
            wb_valid     <= m_valid & ~fault;
            wb_reg_write <= m_reg_write & m_valid & ~fault;
            wb_rd        <= m_rd;
            wb_data      <= wb_sel;
         end else begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
         end
      end
   end

   assign misalign_o      = m_misalign;
   assign fwd_exmem_data  = m_alu;
   assign fwd_memwb_data  = wb_data;
   assign exmem_rd        = m_rd;
   assign exmem_reg_write = m_reg_write & m_valid;

endmodule

// File: tb/tb_pipeline_mem_stage.sv
// Directed bench for pipeline_mem_stage: table of single transactions plus hand-written
// sequences for wait states, back-to-back access, misalignment, timeout and reset.
module tb_pipeline_mem_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ex_valid_i, half, byt, sgn, mem_read_i, mem_write_i, reg_write_i, mem_ack;
   logic [31:0] alu, rs2, pc4, mem_rdata;
   logic [4:0]  rd_i;
   logic [1:0]  mem_to_reg_i;

   // trapping instance (MISALIGN_TRAP=1, MAX_WAIT=4)
   logic        stall_o, mem_req, mem_we, exmem_reg_write, wb_valid, wb_reg_write, misalign_o, bus_err_o;
   logic [31:0] mem_addr, mem_wdata, fwd_exmem_data, fwd_memwb_data, wb_data;
   logic [3:0]  mem_wmask;
   logic [4:0]  exmem_rd, wb_rd;

   // non-trapping instance (MISALIGN_TRAP=0, MAX_WAIT=0)
   logic        n_stall_o, n_mem_req, n_mem_we, n_exmem_reg_write, n_wb_valid, n_wb_reg_write;
   logic        n_misalign_o, n_bus_err_o;
   logic [31:0] n_mem_addr, n_mem_wdata, n_fwd_exmem_data, n_fwd_memwb_data, n_wb_data;
   logic [3:0]  n_mem_wmask;
   logic [4:0]  n_exmem_rd, n_wb_rd;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   pipeline_mem_stage #(.MISALIGN_TRAP(1'b1), .MAX_WAIT(4)) dut (
      .clk(clk), .rst_n(rst_n), .ex_valid_i(ex_valid_i), .ALU_out_EX(alu), .Rs2_out_EX(rs2),
      .Half_out_EX(half), .Byte_out_EX(byt), .Sign_out_EX(sgn), .mem_read_i(mem_read_i),
      .mem_write_i(mem_write_i), .reg_write_i(reg_write_i), .rd_i(rd_i), .mem_to_reg_i(mem_to_reg_i),
      .PC4_out_EX(pc4), .stall_o(stall_o), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .fwd_exmem_data(fwd_exmem_data), .fwd_memwb_data(fwd_memwb_data), .exmem_rd(exmem_rd),
      .exmem_reg_write(exmem_reg_write), .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
      .wb_rd(wb_rd), .wb_data(wb_data), .misalign_o(misalign_o), .bus_err_o(bus_err_o)
   );

   pipeline_mem_stage #(.MISALIGN_TRAP(1'b0), .MAX_WAIT(0)) dut_n (
      .clk(clk), .rst_n(rst_n), .ex_valid_i(ex_valid_i), .ALU_out_EX(alu), .Rs2_out_EX(rs2),
      .Half_out_EX(half), .Byte_out_EX(byt), .Sign_out_EX(sgn), .mem_read_i(mem_read_i),
      .mem_write_i(mem_write_i), .reg_write_i(reg_write_i), .rd_i(rd_i), .mem_to_reg_i(mem_to_reg_i),
      .PC4_out_EX(pc4), .stall_o(n_stall_o), .mem_req(n_mem_req), .mem_we(n_mem_we),
      .mem_addr(n_mem_addr), .mem_wdata(n_mem_wdata), .mem_wmask(n_mem_wmask), .mem_ack(mem_ack),
      .mem_rdata(mem_rdata), .fwd_exmem_data(n_fwd_exmem_data), .fwd_memwb_data(n_fwd_memwb_data),
      .exmem_rd(n_exmem_rd), .exmem_reg_write(n_exmem_reg_write), .wb_valid(n_wb_valid),
      .wb_reg_write(n_wb_reg_write), .wb_rd(n_wb_rd), .wb_data(n_wb_data),
      .misalign_o(n_misalign_o), .bus_err_o(n_bus_err_o)
   );

   typedef struct {
      logic        vld, half, byt, sgn, ld, st, rw;
      logic [31:0] alu, rs2, pc4, rdata;
      logic [4:0]  rd;
      logic [1:0]  m2r;
      logic [31:0] e_wdata;
      logic [3:0]  e_mask;
      logic [31:0] e_wb;
   } vec_t;

   vec_t vecs[15];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic vld, input logic [31:0] a, input logic [31:0] r2,
                               input logic [31:0] p4, input logic [31:0] rdat, input logic h,
                               input logic b, input logic s, input logic ld, input logic st,
                               input logic rw, input logic [4:0] rd, input logic [1:0] m2r,
                               input logic [31:0] ew, input logic [3:0] em, input logic [31:0] ewb);
      vec_t v;
      v.vld = vld; v.alu = a; v.rs2 = r2; v.pc4 = p4; v.rdata = rdat;
      v.half = h; v.byt = b; v.sgn = s; v.ld = ld; v.st = st; v.rw = rw;
      v.rd = rd; v.m2r = m2r; v.e_wdata = ew; v.e_mask = em; v.e_wb = ewb;
      return v;
   endfunction

   task automatic drive_ex(input vec_t v);
      ex_valid_i = v.vld; alu = v.alu; rs2 = v.rs2; pc4 = v.pc4;
      half = v.half; byt = v.byt; sgn = v.sgn; mem_read_i = v.ld; mem_write_i = v.st;
      reg_write_i = v.rw; rd_i = v.rd; mem_to_reg_i = v.m2r;
   endtask

   task automatic clear_ex();
      ex_valid_i = 1'b0; alu = '0; rs2 = '0; pc4 = '0; half = 1'b0; byt = 1'b0; sgn = 1'b0;
      mem_read_i = 1'b0; mem_write_i = 1'b0; reg_write_i = 1'b0; rd_i = '0; mem_to_reg_i = '0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t v;
      int   req_cnt, stall_cnt, err_cnt, wbv_cnt, mis_cnt;

      //            vld alu           rs2           pc4       rdata         h  b  s  ld st rw rd  m2r    wdata         mask     wb
      vecs[0]  = mk(1, 32'h0000_1234, 32'h0,        32'h0,    32'h0,        0, 0, 0, 0, 0, 1, 5,  2'b00, 32'h0,        4'b0000, 32'h0000_1234);
      vecs[1]  = mk(1, 32'h0000_0055, 32'h0,        32'h104,  32'h0,        0, 0, 0, 0, 0, 1, 6,  2'b10, 32'h0,        4'b0000, 32'h0000_0104);
      vecs[2]  = mk(1, 32'h0BAD_F00D, 32'h0,        32'h200,  32'h0,        0, 0, 0, 0, 0, 1, 31, 2'b11, 32'h0,        4'b0000, 32'h0BAD_F00D);
      vecs[3]  = mk(0, 32'h0000_0077, 32'h0,        32'h0,    32'h0,        0, 0, 0, 0, 0, 1, 3,  2'b00, 32'h0,        4'b0000, 32'h0000_0077);
      vecs[4]  = mk(1, 32'h0000_1003, 32'h0,        32'h0,    32'h80FF_0000, 0, 1, 1, 1, 0, 1, 8,  2'b01, 32'h0,       4'b0000, 32'hFFFF_FF80);
      vecs[5]  = mk(1, 32'h0000_1003, 32'h0,        32'h0,    32'h80FF_0000, 0, 1, 0, 1, 0, 1, 8,  2'b01, 32'h0,       4'b0000, 32'h0000_0080);
      vecs[6]  = mk(1, 32'h0000_1002, 32'h0,        32'h0,    32'h8001_1234, 1, 0, 0, 1, 0, 1, 9,  2'b01, 32'h0,       4'b0000, 32'h0000_8001);
      vecs[7]  = mk(1, 32'h0000_1002, 32'h0,        32'h0,    32'h8001_1234, 1, 0, 1, 1, 0, 1, 9,  2'b01, 32'h0,       4'b0000, 32'hFFFF_8001);
      vecs[8]  = mk(1, 32'h0000_1001, 32'h0,        32'h0,    32'h0000_7F00, 0, 1, 1, 1, 0, 1, 10, 2'b01, 32'h0,       4'b0000, 32'h0000_007F);
      vecs[9]  = mk(1, 32'h0000_2000, 32'h0,        32'h0,    32'hCAFE_F00D, 0, 0, 0, 1, 0, 1, 11, 2'b01, 32'h0,       4'b0000, 32'hCAFE_F00D);
      vecs[10] = mk(1, 32'h0000_2000, 32'h0,        32'h0,    32'h1234_8765, 1, 0, 1, 1, 0, 1, 12, 2'b01, 32'h0,       4'b0000, 32'hFFFF_8765);
      vecs[11] = mk(1, 32'h0000_2001, 32'h1234_5678, 32'h0,   32'h0,        0, 1, 0, 0, 1, 0, 0,  2'b00, 32'h7878_7878, 4'b0010, 32'h0000_2001);
      vecs[12] = mk(1, 32'h0000_2002, 32'hAAAA_5555, 32'h0,   32'h0,        1, 0, 0, 0, 1, 0, 0,  2'b00, 32'h5555_5555, 4'b1100, 32'h0000_2002);
      vecs[13] = mk(1, 32'h0000_2000, 32'h0000_BEEF, 32'h0,   32'h0,        1, 0, 0, 0, 1, 0, 0,  2'b00, 32'hBEEF_BEEF, 4'b0011, 32'h0000_2000);
      vecs[14] = mk(1, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0,   32'h0,        0, 0, 0, 0, 1, 0, 0,  2'b00, 32'hDEAD_BEEF, 4'b1111, 32'h0000_1000);

      clear_ex();
      mem_ack = 1'b0;
      mem_rdata = '0;

      // reset values
      repeat (2) @(negedge clk);
      check("rst mem_req", 32'(mem_req), 32'h0);
      check("rst stall", 32'(stall_o), 32'h0);
      check("rst wb_valid", 32'(wb_valid), 32'h0);
      check("rst wb_data", wb_data, 32'h0);
      check("rst wmask", 32'(mem_wmask), 32'h0);
      rst_n = 1'b1;

      // table: one instruction at a time, ack in the first WAIT cycle
      for (int i = 0; i < 15; i++) begin
         v = vecs[i];
         @(negedge clk);
         drive_ex(v);
         @(negedge clk);
         clear_ex();
         check($sformatf("v%0d fwd_exmem", i), fwd_exmem_data, v.alu);
         check($sformatf("v%0d exmem_rd", i), 32'(exmem_rd), 32'(v.rd));
         check($sformatf("v%0d exmem_rw", i), 32'(exmem_reg_write), 32'(v.rw & v.vld));
         if (v.ld || v.st) begin
            check($sformatf("v%0d mem_req", i), 32'(mem_req), 32'h1);
            check($sformatf("v%0d mem_we", i), 32'(mem_we), 32'(v.st));
            check($sformatf("v%0d mem_addr", i), mem_addr, {v.alu[31:2], 2'b00});
            check($sformatf("v%0d wmask", i), 32'(mem_wmask), 32'(v.e_mask));
            if (v.st) check($sformatf("v%0d wdata", i), mem_wdata, v.e_wdata);
            mem_ack = 1'b1;
            mem_rdata = v.rdata;
            #1 check($sformatf("v%0d stall_ack", i), 32'(stall_o), 32'h0);
         end else begin
            check($sformatf("v%0d no_req", i), 32'(mem_req), 32'h0);
         end
         @(negedge clk);
         mem_ack = 1'b0;
         check($sformatf("v%0d wb_valid", i), 32'(wb_valid), 32'(v.vld));
         check($sformatf("v%0d wb_rw", i), 32'(wb_reg_write), 32'(v.rw & v.vld));
         check($sformatf("v%0d wb_rd", i), 32'(wb_rd), 32'(v.rd));
         check($sformatf("v%0d wb_data", i), wb_data, v.e_wb);
         check($sformatf("v%0d fwd_memwb", i), fwd_memwb_data, v.e_wb);
      end

      // SW with ack in the third WAIT cycle: two stall cycles, writeback after ack
      @(negedge clk);
      drive_ex(vecs[14]);
      stall_cnt = 0;
      @(negedge clk);
      clear_ex();
      check("sw mem_addr", mem_addr, 32'h0000_1000);
      check("sw wmask", 32'(mem_wmask), 32'hF);
      for (int c = 0; c < 3; c++) begin
         if (c > 0) @(negedge clk);
         mem_ack = (c == 2);
         #1;
         if (stall_o) stall_cnt++;
         check($sformatf("sw wait%0d wb_valid", c), 32'(wb_valid), 32'h0);
      end
      check("sw stall cycles", 32'(stall_cnt), 32'd2);
      @(negedge clk);
      mem_ack = 1'b0;
      check("sw wb_valid", 32'(wb_valid), 32'h1);
      check("sw req dropped", 32'(mem_req), 32'h0);

      // SB followed by LW acked in the same cycle: WAIT->WAIT without an idle gap
      @(negedge clk);
      drive_ex(vecs[11]);
      @(negedge clk);
      check("b2b sb wdata", mem_wdata, 32'h7878_7878);
      check("b2b sb wmask", 32'(mem_wmask), 32'h2);
      v = mk(1, 32'h0000_1004, 32'h0, 32'h0, 32'h0, 0, 0, 0, 1, 0, 1, 7, 2'b01, 32'h0, 4'b0, 32'h0);
      drive_ex(v);
      mem_ack = 1'b1;
      @(negedge clk);
      clear_ex();
      check("b2b lw mem_req", 32'(mem_req), 32'h1);
      check("b2b lw mem_we", 32'(mem_we), 32'h0);
      check("b2b lw mem_addr", mem_addr, 32'h0000_1004);
      check("b2b sb wb_valid", 32'(wb_valid), 32'h1);
      check("b2b sb wb_rw", 32'(wb_reg_write), 32'h0);
      mem_rdata = 32'hA5A5_0F0F;
      @(negedge clk);
      mem_ack = 1'b0;
      check("b2b lw wb_valid", 32'(wb_valid), 32'h1);
      check("b2b lw wb_rd", 32'(wb_rd), 32'd7);
      check("b2b lw wb_data", wb_data, 32'hA5A5_0F0F);

      // misaligned LW at 0x1002: trapped in one instance, aligned and performed in the other
      @(negedge clk);
      v = mk(1, 32'h0000_1002, 32'h0, 32'h0, 32'h0, 0, 0, 0, 1, 0, 1, 9, 2'b01, 32'h0, 4'b0, 32'h0);
      drive_ex(v);
      mis_cnt = 0;
      @(negedge clk);
      clear_ex();
      if (misalign_o) mis_cnt++;
      check("mis trap no_req", 32'(mem_req), 32'h0);
      check("mis trap stall", 32'(stall_o), 32'h0);
      check("mis align req", 32'(n_mem_req), 32'h1);
      check("mis align addr", n_mem_addr, 32'h0000_1000);
      check("mis align no_flag", 32'(n_misalign_o), 32'h0);
      mem_ack = 1'b1;
      mem_rdata = 32'h1122_3344;
      @(negedge clk);
      mem_ack = 1'b0;
      if (misalign_o) mis_cnt++;
      check("mis trap wb_valid", 32'(wb_valid), 32'h0);
      check("mis trap wb_rw", 32'(wb_reg_write), 32'h0);
      check("mis align wb_valid", 32'(n_wb_valid), 32'h1);
      check("mis align wb_data", n_wb_data, 32'h1122_3344);
      @(negedge clk);
      if (misalign_o) mis_cnt++;
      check("mis pulse count", 32'(mis_cnt), 32'd1);

      // LW never acked: four request cycles, then abort with a bus error and a bubble
      @(negedge clk);
      v = mk(1, 32'h0000_3000, 32'h0, 32'h0, 32'h0, 0, 0, 0, 1, 0, 1, 4, 2'b01, 32'h0, 4'b0, 32'h0);
      drive_ex(v);
      req_cnt = 0; stall_cnt = 0; err_cnt = 0; wbv_cnt = 0;
      @(negedge clk);
      clear_ex();
      for (int c = 0; c < 8; c++) begin
         if (c > 0) @(negedge clk);
         if (mem_req) req_cnt++;
         if (stall_o) stall_cnt++;
         if (bus_err_o) err_cnt++;
         if (wb_valid) wbv_cnt++;
      end
      check("tmo req cycles", 32'(req_cnt), 32'd4);
      check("tmo stall cycles", 32'(stall_cnt), 32'd3);
      check("tmo bus_err pulses", 32'(err_cnt), 32'd1);
      check("tmo wb_valid", 32'(wbv_cnt), 32'd0);
      check("tmo disabled still stalls", 32'(n_stall_o), 32'h1);

      // reset while a store is in flight
      @(negedge clk);
      drive_ex(vecs[14]);
      @(negedge clk);
      clear_ex();
      check("rstw req before", 32'(mem_req), 32'h1);
      #2 rst_n = 1'b0;
      #1;
      check("rstw mem_req", 32'(mem_req), 32'h0);
      check("rstw mem_we", 32'(mem_we), 32'h0);
      check("rstw wmask", 32'(mem_wmask), 32'h0);
      check("rstw wdata", mem_wdata, 32'h0);
      check("rstw fwd_exmem", fwd_exmem_data, 32'h0);
      check("rstw wb_data", wb_data, 32'h0);
      check("rstw stall n", 32'(n_stall_o), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rstw idle req", 32'(mem_req), 32'h0);
      check("rstw idle stall", 32'(stall_o), 32'h0);
      check("rstw idle wb_valid", 32'(wb_valid), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
